// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer
//
// Drives the three PWM inputs and the enable of the SB_RGBA_DRV RGB LED
// driver. Colour commands arrive over a valid/ready handshake. Each command
// either jumps to a 24-bit target colour or fades linearly toward it one
// LSB per channel per step. It then holds for a programmed number of PWM
// periods and pulses done.
//
// Parameters:
//   PRESCALE      PWM counter advances once every PRESCALE+1 clocks
//   FADE_PERIODS  PWM periods per fade step (1..255)
//
// Ports:
//   hw_clk      in   oscillator clock, the only clock
//   rst_n       in   asynchronous active-low reset
//   cmd_valid   in   command present
//   cmd_ready   out  block can accept a command (registered)
//   cmd_color   in   target colour {R[23:16], G[15:8], B[7:0]}
//   cmd_fade    in   1 = fade to target, 0 = jump to target
//   cmd_hold    in   hold time in PWM periods
//   pwm_r/g/b   out  registered PWM to RGB0PWM / RGB1PWM / RGB2PWM
//   led_en      out  registered enable to RGBLEDEN and CURREN
//   busy        out  a command is in progress
//   done        out  one-cycle pulse when a command completes
module rgb_led_sequencer #(
  parameter int PRESCALE     = 47,
  parameter int FADE_PERIODS = 4
) (
  input  logic        hw_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_color,
  input  logic        cmd_fade,
  input  logic [7:0]  cmd_hold,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        led_en,
  output logic        busy,
  output logic        done
);

  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE);
  localparam logic [7:0]    STEP_LAST  = 8'(FADE_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc_cnt;
  logic [7:0]    pwm_cnt;
  logic          tick;
  logic          pstart;
  logic [23:0]   duty_cur;
  logic [23:0]   duty_act;
  logic [23:0]   duty_next;
  logic [23:0]   target;
  logic [7:0]    hold_len;
  logic [7:0]    hold_cnt;
  logic [7:0]    step_cnt;

  // Move one LSB toward the target; a channel already there stays put, so a
  // step can never overshoot or wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  assign tick   = (presc_cnt == PRESC_LAST);
  assign pstart = tick && (pwm_cnt == 8'd255);

  always_comb begin
    duty_next = {step_toward(duty_cur[23:16], target[23:16]),
                 step_toward(duty_cur[15:8],  target[15:8]),
                 step_toward(duty_cur[7:0],   target[7:0])};
  end

  // PWM timebase and output stage. duty_act only follows duty_cur at the
  // start of a PWM period so a colour change never produces a runt pulse.
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= 8'd0;
      duty_act  <= 24'd0;
      pwm_r     <= 1'b0;
      pwm_g     <= 1'b0;
      pwm_b     <= 1'b0;
      led_en    <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      if (pstart) duty_act <= duty_cur;
      pwm_r  <= (pwm_cnt < duty_act[23:16]);
      pwm_g  <= (pwm_cnt < duty_act[15:8]);
      pwm_b  <= (pwm_cnt < duty_act[7:0]);
      led_en <= busy | (|duty_act);
    end
  end

  // Command FSM. cmd_ready comes up one edge after reset and again on the
  // edge that re-enters IDLE, so a waiting command is taken with no gap.
  // A pstart coinciding with the accept edge is seen while still in IDLE
  // and therefore never counts toward the new command.
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      duty_cur  <= 24'd0;
      target    <= 24'd0;
      hold_len  <= 8'd0;
      hold_cnt  <= 8'd0;
      step_cnt  <= 8'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            target    <= cmd_color;
            hold_len  <= cmd_hold;
            if (!cmd_fade) begin
              duty_cur <= cmd_color;
              hold_cnt <= cmd_hold;
              state    <= HOLD;
            end else if (cmd_color == duty_cur) begin
              hold_cnt <= cmd_hold;
              state    <= HOLD;
            end else begin
              step_cnt <= 8'd0;
              state    <= FADE;
            end
          end
        end
        FADE: begin
          if (pstart) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= 8'd0;
              duty_cur <= duty_next;
              if (duty_next == target) begin
                hold_cnt <= hold_len;
                state    <= HOLD;
              end
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == 8'd0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
          end else if (pstart) begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Testbench for rgb_led_sequencer with PRESCALE=0, so one PWM period is
// 256 clocks. The bench counts clock edges since reset release in cyc. With
// PRESCALE=0 the PWM counter is cyc mod 256 after each edge, so a pstart
// occurs on every edge whose number is a multiple of 256. All expected
// timings are derived from the accept edge number through that model.
module tb_rgb_led_sequencer;

  logic        hw_clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_color;
  logic        cmd_fade;
  logic [7:0]  cmd_hold;
  logic        pwm_r, pwm_g, pwm_b, led_en, busy, done;

  logic        valid3;
  logic        ready3;
  logic        pwm_r3, pwm_g3, pwm_b3, led_en3, busy3, done3;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;

  always #5 hw_clk = ~hw_clk;

  rgb_led_sequencer #(.PRESCALE(0), .FADE_PERIODS(1)) dut (
    .hw_clk(hw_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_color(cmd_color), .cmd_fade(cmd_fade), .cmd_hold(cmd_hold),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .led_en(led_en), .busy(busy), .done(done)
  );

  rgb_led_sequencer #(.PRESCALE(0), .FADE_PERIODS(3)) dut3 (
    .hw_clk(hw_clk), .rst_n(rst_n),
    .cmd_valid(valid3), .cmd_ready(ready3),
    .cmd_color(cmd_color), .cmd_fade(cmd_fade), .cmd_hold(cmd_hold),
    .pwm_r(pwm_r3), .pwm_g(pwm_g3), .pwm_b(pwm_b3),
    .led_en(led_en3), .busy(busy3), .done(done3)
  );

  // Edge counter since reset release; cleared with the DUT reset.
  always @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  // Counts every done pulse of the main DUT so lost or doubled completions
  // show up.
  always @(negedge hw_clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  // Edge number of the k-th pstart strictly after edge n.
  function automatic int pk(input int n, input int k);
    return (n / 256 + k) * 256;
  endfunction

  task automatic checkOutput(input string tag, input int got, input int expect_val);
    vectors = vectors + 1;
    if (got !== expect_val) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", tag, got, expect_val, cyc);
    end
  endtask

  // Presents a command from a negedge and holds it until the DUT takes it.
  // Returns the edge number on which it was accepted; ends on a negedge.
  task automatic applyStimulus(input logic [23:0] color, input logic fade,
                               input logic [7:0] hold, output int acc);
    int n;
    cmd_color = color;
    cmd_fade  = fade;
    cmd_hold  = hold;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge hw_clk);
      n++;
    end
    if (n >= 5000) checkOutput("accept_timeout", 0, 1);
    @(negedge hw_clk);
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 70000) begin
      @(negedge hw_clk);
      n++;
    end
    if (cyc != target) checkOutput("wait_target", cyc, target);
  endtask

  // Counts high samples of each output over the next 256 clocks.
  task automatic measurePeriod(output int r, output int g, output int b, output int l);
    r = 0; g = 0; b = 0; l = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge hw_clk);
      r += int'(pwm_r);
      g += int'(pwm_g);
      b += int'(pwm_b);
      l += int'(led_en);
    end
  endtask

  function automatic int outsMain();
    return int'({cmd_ready, pwm_r, pwm_g, pwm_b, led_en, busy, done});
  endfunction

  // Jump to 0x8000FF, hold 2, starting at the negedge of edge 1 after reset.
  task automatic runJump(input string tag);
    int acc, r, g, b, l, dc;
    dc = done_cnt;
    applyStimulus(24'h8000FF, 1'b0, 8'd2, acc);
    checkOutput({tag, "_accept_edge"}, acc, 2);
    checkOutput({tag, "_ready_low"}, int'(cmd_ready), 0);
    checkOutput({tag, "_busy"}, int'(busy), 1);
    waitUntil(pk(acc, 1));
    measurePeriod(r, g, b, l);
    checkOutput({tag, "_r_duty"}, r, 128);
    checkOutput({tag, "_g_duty"}, g, 0);
    checkOutput({tag, "_b_duty"}, b, 255);
    checkOutput({tag, "_led_en"}, l, 256);
    waitUntil(pk(acc, 2) + 1);
    checkOutput({tag, "_done"}, int'(done), 1);
    checkOutput({tag, "_ready_with_done"}, int'(cmd_ready), 1);
    checkOutput({tag, "_busy_clear"}, int'(busy), 0);
    @(negedge hw_clk);
    checkOutput({tag, "_done_one_cycle"}, int'(done), 0);
    checkOutput({tag, "_done_count"}, done_cnt - dc, 1);
  endtask

  initial begin
    int acc, acc_a, acc_b, r, g, b, l, dc, n, d3;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    valid3    = 1'b0;
    cmd_color = 24'd0;
    cmd_fade  = 1'b0;
    cmd_hold  = 8'd0;

    // Reset and ready rise
    repeat (10) @(negedge hw_clk);
    checkOutput("reset_outputs", outsMain(), 0);
    checkOutput("reset_outputs_fp3",
                int'({ready3, pwm_r3, pwm_g3, pwm_b3, led_en3, busy3, done3}), 0);
    rst_n = 1'b1;
    checkOutput("ready_at_release", int'(cmd_ready), 0);
    @(negedge hw_clk);
    checkOutput("ready_after_release", int'(cmd_ready), 1);

    runJump("jump");

    // Fade from black to 0x040200
    applyStimulus(24'h000000, 1'b0, 8'd0, acc);
    waitUntil(acc + 1);
    checkOutput("black_done", int'(done), 1);
    applyStimulus(24'h040200, 1'b1, 8'd0, acc);
    waitUntil(pk(acc, 3));
    measurePeriod(r, g, b, l);
    checkOutput("fade_r_after2", r, 2);
    checkOutput("fade_g_after2", g, 2);
    checkOutput("fade_b_after2", b, 0);
    checkOutput("fade_busy_step4", int'(busy), 1);
    waitUntil(pk(acc, 4) + 1);
    checkOutput("fade_done", int'(done), 1);
    waitUntil(pk(acc, 5));
    measurePeriod(r, g, b, l);
    checkOutput("fade_r_final", r, 4);
    checkOutput("fade_g_final", g, 2);
    checkOutput("fade_b_final", b, 0);

    // Backpressure: second command waits for the first to finish
    applyStimulus(24'h112233, 1'b0, 8'd1, acc_a);
    checkOutput("bp_ready_low", int'(cmd_ready), 0);
    dc = done_cnt;
    applyStimulus(24'h445566, 1'b0, 8'd0, acc_b);
    checkOutput("bp_accept_edge", acc_b, pk(acc_a, 1) + 2);
    waitUntil(acc_b + 1);
    checkOutput("bp_second_done", int'(done), 1);
    @(negedge hw_clk);
    checkOutput("bp_done_count", done_cnt - dc, 2);
    waitUntil(pk(acc_b, 1));
    measurePeriod(r, g, b, l);
    checkOutput("bp_r", r, 8'h44);
    checkOutput("bp_g", g, 8'h55);
    checkOutput("bp_b", b, 8'h66);

    // Fade down by two steps, then a no-op command
    applyStimulus(24'hFF0000, 1'b0, 8'd0, acc);
    waitUntil(acc + 1);
    applyStimulus(24'hFD0000, 1'b1, 8'd0, acc);
    waitUntil(pk(acc, 1) + 1);
    checkOutput("down_not_done_step1", int'(done), 0);
    checkOutput("down_busy_step1", int'(busy), 1);
    waitUntil(pk(acc, 2) + 1);
    checkOutput("down_done_step2", int'(done), 1);
    applyStimulus(24'hFD0000, 1'b1, 8'd0, acc);
    checkOutput("noop_busy", int'(busy), 1);
    waitUntil(acc + 1);
    checkOutput("noop_done", int'(done), 1);

    // Fade to black: led_en drops once duty_act reaches 0
    applyStimulus(24'h000100, 1'b0, 8'd0, acc);
    waitUntil(acc + 1);
    applyStimulus(24'h000000, 1'b1, 8'd0, acc);
    waitUntil(pk(acc, 1) + 1);
    checkOutput("off_done", int'(done), 1);
    waitUntil(pk(acc, 2));
    checkOutput("off_led_en_still_on", int'(led_en), 1);
    checkOutput("off_busy_clear", int'(busy), 0);
    @(negedge hw_clk);
    checkOutput("off_led_en_off", int'(led_en), 0);

    // FADE_PERIODS=3 instance: 4 steps take 12 periods
    cmd_color = 24'h040200;
    cmd_fade  = 1'b1;
    cmd_hold  = 8'd0;
    valid3    = 1'b1;
    @(negedge hw_clk);
    acc = cyc;
    valid3 = 1'b0;
    n  = 0;
    d3 = -1;
    while (n < 5000 && d3 < 0) begin
      @(negedge hw_clk);
      if (done3 === 1'b1) d3 = cyc;
      n++;
    end
    checkOutput("fp3_done_edge", d3, pk(acc, 12) + 1);

    // Reset in the middle of a fade
    applyStimulus(24'h0A0A0A, 1'b1, 8'd0, acc);
    waitUntil(pk(acc, 2) + 1);
    checkOutput("mid_pwm_r_before_reset", int'(pwm_r), 1);
    dc = done_cnt;
    #2 rst_n = 1'b0;
    #1 checkOutput("mid_reset_outputs", outsMain(), 0);
    repeat (5) @(negedge hw_clk);
    checkOutput("mid_reset_no_done", done_cnt - dc, 0);
    rst_n = 1'b1;
    @(negedge hw_clk);
    checkOutput("mid_ready_after_release", int'(cmd_ready), 1);
    runJump("rejump");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
